data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data memory for the MIPS pipeline's MEM stage. It supports byte, halfword and word stores through per-lane byte enables, and LB/LBU/LH/LHU/LW loads with sign or zero extension. Responses are registered, with a fixed one-cycle latency behind a valid/ready request handshake. Reset clears the array sequentially rather than in one cycle. Every completed store is reported on a trace port as the merged aligned word, which replaces simulation-only printing.

## Interface
- DEPTH_WORDS, default 2048: number of 32-bit words; power of two, ≥ 4.
- CLEAR_ON_RESET, default 1: 1 zeroes the array after reset; 0 skips clearing (contents undefined).
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  01 byte, 10 half, 11 word, 00 illegal.
- req_signed  in  1  loads only: 1 sign-extends, 0 zero-extends.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- req_pc  in  32  PC of the issuing instruction, used for trace only.
- rsp_valid  out  1  one-cycle pulse: response for the request accepted on the previous edge.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_error  out  1  request was rejected (misaligned, illegal size, or out of range).
- trace_valid  out  1  a store committed; qualifies the trace fields.
- trace_pc, trace_addr, trace_data  out  32 each  PC, word-aligned address ({addr[31:2],2'b00}), full word after merge.
- busy  out  1  clear in progress.

## Operation
- FSM states: CLEAR and RUN.
  - Reset forces CLEAR and sets the clear counter to 0.
  - In CLEAR, one word is zeroed per cycle, word[counter] <= 0, counter++.
  - After word DEPTH_WORDS-1 is zeroed, the FSM moves to RUN.
  - With CLEAR_ON_RESET=0, reset goes directly to RUN.
- req_ready = (state == RUN) && !reset. busy = (state == CLEAR).
- A request is accepted on an edge where req_valid && req_ready. At most one request is accepted per cycle; there is no internal queue.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]. Lane = req_addr[1:0].
- An access is in range when req_addr[31:log2(DEPTH_WORDS)+2] == 0.
- Error conditions:
  - size 00;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - out of range.

  On error: no array write, no trace, rsp_error = 1, rsp_rdata = 0.
- Store byte enables:
  - byte: 1 << lane;
  - half: 0011 or 1100, selected by addr[1];
  - word: 1111.

  Write data is replicated across lanes: the byte is copied to all four lanes, the half to both halves. Only the enabled lanes are written.
- Load:
  - The aligned word is read synchronously.
  - The selected byte (lane) or half (addr[1]) is shifted to bit 0.
  - If req_signed = 1, the result is extended with its MSB; otherwise with zeros.
  - Word loads ignore req_signed.
- Trace:
  - On every successful store, trace_data = (old_word & ~mask) | (new_lanes & mask).
  - It is computed from the pre-write array contents together with the enables.

## Timing
- Latency: a request accepted at edge N produces rsp_valid, rsp_* and trace_* during cycle N+1, valid until edge N+1. Each output is a single-cycle pulse.
- Back-to-back requests are allowed every cycle. A load at N+1 to a word stored at N returns the stored data; no forwarding is required because the write completes at edge N.
- Reset values: req_ready = 0, busy = 1 (0 if CLEAR_ON_RESET=0 after the first edge), rsp_valid = 0, rsp_error = 0, rsp_rdata = 0, trace_valid = 0, and all trace fields = 0.
- Clear duration: exactly DEPTH_WORDS cycles after reset deasserts. req_ready first rises in cycle DEPTH_WORDS after deassertion.
- Reset during CLEAR restarts the counter at 0.
- Reset during RUN squashes any pending response: rsp_valid and trace_valid are 0 on the following cycle, and a store accepted on the same edge as reset is not written.
- The counter is exactly log2(DEPTH_WORDS) bits; the last word is cleared without any wrap to word 0.

## Test plan
- Reset sequence, DEPTH_WORDS=16: assert reset 2 cycles, then release → busy = 1 for 16 cycles, req_ready rises in cycle 16, and an LW of 0x3C returns 0.
- SW 0x11223344 @0x8, then SB 0xAB @0xA → trace_data 0x11223344 then 0x11AB3344, with trace_addr 0x8 both times. Then LB @0xA → 0xFFFFFFAB and LBU @0xA → 0x000000AB.
- SH 0x8001 @0x6 → trace_data 0x80010000. Then LH @0x6 → 0xFFFF8001 and LHU @0x6 → 0x00008001.
- Error cases:
  - SH @0x5 → rsp_error = 1, no trace.
  - LW @0x2 → rsp_error = 1, rsp_rdata = 0.
  - Size 00 → rsp_error = 1.
  - LW @(DEPTH_WORDS*4) → rsp_error = 1.
  - Memory contents must be unchanged after all of the above.
- Back-to-back stream, no bubbles: SW 0xDEADBEEF @0x0 followed immediately by LW @0x0 → rsp_rdata 0xDEADBEEF one cycle after the store's response.
- Reset asserted on the same edge as an accepted SW @0x4 → no trace, and after the clear completes LW @0x4 = 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte/half/word data memory for the MEM stage with registered
// one-cycle responses, a store trace port and a sequential clear after reset.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS    = 2048,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        trace_valid,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic {CLEAR, RUN} state_t;
    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [AW-1:0] w_idx;
    logic          w_acc, w_err, w_store;
    logic [31:0]   w_old, w_shift, w_load, w_wrep, w_bmask, w_merged;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [3:0]    w_mask;

    assign req_ready = (r_state == RUN) && !reset;
    assign busy      = (r_state == CLEAR);
    assign w_acc     = req_valid && req_ready;
    assign w_idx     = req_addr[AW+1:2];
    assign w_err     = (req_size == 2'b00) || (req_size == 2'b10 && req_addr[0]) ||
                       (req_size == 2'b11 && req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign w_store   = w_acc && !w_err && req_write;
    assign w_old     = r_mem[w_idx];
    assign w_shift   = w_old >> {req_addr[1:0], 3'b000};
    assign w_byte    = w_shift[7:0];
    assign w_half    = req_addr[1] ? w_old[31:16] : w_old[15:0];
    assign w_load    = req_size == 2'b11 ? w_old :
                       req_size == 2'b01 ? {{24{req_signed & w_byte[7]}}, w_byte} :
                                           {{16{req_signed & w_half[15]}}, w_half};
    assign w_mask    = req_size == 2'b01 ? 4'b0001 << req_addr[1:0] :
                       req_size == 2'b10 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wrep    = req_size == 2'b01 ? {4{req_wdata[7:0]}} :
                       req_size == 2'b10 ? {2{req_wdata[15:0]}} : req_wdata;
    assign w_bmask   = {{8{w_mask[3]}}, {8{w_mask[2]}}, {8{w_mask[1]}}, {8{w_mask[0]}}};
    assign w_merged  = (w_old & ~w_bmask) | (w_wrep & w_bmask);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == CLEAR) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (&r_cnt) w_state_nxt = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= CLEAR_ON_RESET ? CLEAR : RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The pre-write word is merged and written whole, so the trace sees the same value.
    always_ff @(posedge clock) begin
        if (!reset && r_state == CLEAR) r_mem[r_cnt] <= '0;
        else if (w_store) r_mem[w_idx] <= w_merged;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid   <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_rdata   <= '0;
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
        end else begin
            rsp_valid   <= w_acc;
            rsp_error   <= w_acc && w_err;
            rsp_rdata   <= (w_acc && !w_err && !req_write) ? w_load : '0;
            trace_valid <= w_store;
            trace_pc    <= w_store ? req_pc : '0;
            trace_addr  <= w_store ? {req_addr[31:2], 2'b00} : '0;
            trace_data  <= w_store ? w_merged : '0;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed vector table plus random requests checked against
// a byte-array memory model; covers clear timing, errors and reset squashing.
module tb_data_mem_ctrl;
    localparam int D = 16;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic        rsp_valid, rsp_error, trace_valid, busy;
    logic [31:0] rsp_rdata, trace_pc, trace_addr, trace_data;
    int          errs = 0, checks = 0;
    logic [7:0]  mb [D*4];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad, wd;
        logic        er;
        logic [31:0] rd, td;
    } vec_t;
    vec_t tbl [15];

    data_mem_ctrl #(.DEPTH_WORDS(D), .CLEAR_ON_RESET(1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
        .trace_data(trace_data), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // Little-endian byte memory: bytes addr..addr+n-1, extension by the top loaded byte.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd, output logic er, output logic [31:0] rd,
                         output logic [31:0] td);
        int n;
        n  = sz == 2'd1 ? 1 : sz == 2'd2 ? 2 : 4;
        er = sz == 2'd0 || (sz == 2'd2 && ad[0]) || (sz == 2'd3 && ad[1:0] != 2'd0) || ad >= D*4;
        rd = '0;
        td = '0;
        if (er) return;
        if (w) begin
            for (int i = 0; i < n; i++) mb[ad+i] = wd[8*i +: 8];
            for (int i = 0; i < 4; i++) td[8*i +: 8] = mb[{ad[31:2], 2'b00} + i];
        end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = mb[ad+i];
            if (sg && n < 4 && rd[8*n-1])
                for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
        end
    endtask

    task automatic req_chk(input string n, input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd, input logic er,
                           input logic [31:0] rd, input logic [31:0] td);
        logic [31:0] pc;
        pc = $urandom;
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = ad; req_wdata = wd; req_pc = pc;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk({n, " rsp_valid"}, rsp_valid, 1);
        chk({n, " rsp_error"}, rsp_error, er);
        chk({n, " rsp_rdata"}, rsp_rdata, rd);
        chk({n, " trace_valid"}, trace_valid, w && !er);
        if (w && !er) begin
            chk({n, " trace_data"}, trace_data, td);
            chk({n, " trace_addr"}, trace_addr, {ad[31:2], 2'b00});
            chk({n, " trace_pc"}, trace_pc, pc);
        end
    endtask

    task automatic rand_req(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] ad, input logic [31:0] wd);
        logic er;
        logic [31:0] rd, td;
        model(w, sz, sg, ad, wd, er, rd, td);
        req_chk("rand", w, sz, sg, ad, wd, er, rd, td);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clock); #1;
        chk("idle rsp_valid", rsp_valid, 0);
        chk("idle trace_valid", trace_valid, 0);
    endtask

    task automatic wait_clear();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("clear cycles", n, D);
        chk("ready after clear", req_ready, 1);
        for (int i = 0; i < D*4; i++) mb[i] = 8'h00;
    endtask

    initial begin
        logic er;
        logic [31:0] rd, td;
        tbl[0]  = '{1'b1, 2'd3, 1'b0, 32'h08, 32'h11223344, 1'b0, 32'h0, 32'h11223344};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, 32'h0A, 32'h000000AB, 1'b0, 32'h0, 32'h11AB3344};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 1'b0, 32'hFFFFFFAB, 32'h0};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 1'b0, 32'h000000AB, 32'h0};
        tbl[4]  = '{1'b1, 2'd2, 1'b0, 32'h06, 32'h00008001, 1'b0, 32'h0, 32'h80010000};
        tbl[5]  = '{1'b0, 2'd2, 1'b1, 32'h06, 32'h0, 1'b0, 32'hFFFF8001, 32'h0};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 1'b0, 32'h00008001, 32'h0};
        tbl[7]  = '{1'b1, 2'd2, 1'b0, 32'h05, 32'h0000FFFF, 1'b1, 32'h0, 32'h0};
        tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, 32'h0};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h08, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h0};
        tbl[10] = '{1'b0, 2'd3, 1'b0, D*4, 32'h0, 1'b1, 32'h0, 32'h0};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 1'b0, 32'h11AB3344, 32'h0};
        tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h04, 32'h0, 1'b0, 32'h80010000, 32'h0};
        tbl[13] = '{1'b1, 2'd3, 1'b0, 32'h00, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF};
        tbl[14] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0};

        repeat (2) @(posedge clock);
        #1;
        chk("reset req_ready", req_ready, 0);
        chk("reset busy", busy, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_error", rsp_error, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset trace_valid", trace_valid, 0);
        chk("reset trace_data", trace_data, 0);
        chk("reset trace_addr", trace_addr, 0);
        @(negedge clock);
        reset = 1'b0;
        wait_clear();
        req_chk("LW 0x3C", 1'b0, 2'd3, 1'b0, 32'h3C, 32'h0, 1'b0, 32'h0, 32'h0);

        // Issued back-to-back with no idle cycles between vectors.
        for (int i = 0; i < 15; i++) begin
            model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].ad, tbl[i].wd, er, rd, td);
            req_chk($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].ad,
                    tbl[i].wd, tbl[i].er, tbl[i].rd, tbl[i].td);
        end
        idle();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else rand_req(1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) == 0 ? 2'd0 : 2'(1 + $urandom_range(0, 2)),
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, D*4-1)),
                          $urandom);
        end

        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 32'h4;
        req_wdata = 32'h5A5A5A5A; reset = 1'b1;
        @(posedge clock); #1;
        chk("rst-store rsp_valid", rsp_valid, 0);
        chk("rst-store trace_valid", trace_valid, 0);
        @(negedge clock);
        reset = 1'b0;
        req_valid = 1'b0;
        wait_clear();
        req_chk("LW 0x4 after reset", 1'b0, 2'd3, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'h0);
        idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
